rom_select: RTL

- Parametrised successor to the single-button reload logic in the NES top level.
- Synchronises and debounces N active-low board buttons and tracks a ROM/game index.
- Issues a one-cycle reload pulse to main_mem on button release.
- Supports direct-select mode (button number plus shift) and step mode (next/prev with wrap-around).

---
 rtl/rom_select.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/rom_select.sv
// ROM/game index selector: synchronises and debounces active-low buttons,
// commits a new index on release and pulses reload for one cycle.
//
// Ports:
//   clock  - system clock
//   reset  - synchronous, active-high
//   btn_n  - raw active-low buttons; the top bit is shift
//   index  - committed ROM index, stable between reloads
//   reload - one-cycle pulse; index is already valid in the same cycle
//   held   - high while a select button press is being held
//   btn_db - debounced buttons, active-high
module rom_select #(
    parameter int NUM_BTNS        = 5,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int INDEX_W         = 4,
    parameter int NUM_ROMS        = 16,
    parameter int STEP_MODE       = 0,
    parameter int STEP_BIG        = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn_n,
    output logic [INDEX_W-1:0]  index,
    output logic                reload,
    output logic                held,
    output logic [NUM_BTNS-1:0] btn_db
);
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int NSEL   = NUM_BTNS - 1;
    localparam int CAND_W = (NSEL > 1) ? $clog2(NSEL) : 1;
    localparam int SUM_W  = INDEX_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SUM_W-1:0] ROMS_X   = SUM_W'(NUM_ROMS);

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    logic [NUM_BTNS-1:0] sync1;
    logic [NUM_BTNS-1:0] sync2;
    logic [NUM_BTNS-1:0] pressed;
    logic [CNT_W-1:0]    cnt [NUM_BTNS];

    logic [NSEL-1:0]     sel;
    logic                any_sel;
    logic [CAND_W-1:0]   low_sel;

    state_t              state;
    state_t              state_nx;
    logic                commit;
    logic [CAND_W-1:0]   cand;
    logic                shf;

    logic [31:0]         direct_new;
    logic [SUM_W-1:0]    step;
    logic [SUM_W-1:0]    step_raw;
    logic [SUM_W-1:0]    step_wrap;
    logic [INDEX_W-1:0]  new_idx;
    logic                new_ok;

    // Two-flop synchroniser, released (high) out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    assign pressed = ~sync2;

    // A bit flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_db <= '0;
            for (int i = 0; i < NUM_BTNS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (pressed[i] == btn_db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    btn_db[i] <= ~btn_db[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign sel     = btn_db[NSEL-1:0];
    assign any_sel = |sel;

    // Lowest-numbered pressed select button wins.
    always_comb begin
        low_sel = '0;
        for (int i = NSEL - 1; i >= 0; i--) begin
            if (sel[i]) begin
                low_sel = CAND_W'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_sel) begin
                    state_nx = HELD;
                end
            end
            HELD: begin
                if (!any_sel) begin
                    state_nx = IDLE;
                    commit   = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Candidate and shift are frozen at the first press.
    always_ff @(posedge clock) begin
        if (reset) begin
            cand <= '0;
            shf  <= 1'b0;
        end else if (state == IDLE && any_sel) begin
            cand <= low_sel;
            shf  <= btn_db[NUM_BTNS-1];
        end
    end

    // Step arithmetic is done one bit wider so the wrap test sees overflow.
    always_comb begin
        direct_new = 32'(cand) + (shf ? 32'(NSEL) : 32'd0);
        step       = shf ? SUM_W'(STEP_BIG) : SUM_W'(1);
        if (cand == CAND_W'(0)) begin
            step_raw = {1'b0, index} + step;
        end else begin
            step_raw = {1'b0, index} + ROMS_X - step;
        end
        if (step_raw >= ROMS_X) begin
            step_wrap = step_raw - ROMS_X;
        end else begin
            step_wrap = step_raw;
        end
        if (STEP_MODE != 0) begin
            new_idx = INDEX_W'(step_wrap);
            new_ok  = (cand == CAND_W'(0)) || (cand == CAND_W'(1));
        end else begin
            new_idx = INDEX_W'(direct_new);
            new_ok  = direct_new < 32'(NUM_ROMS);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            index  <= '0;
            reload <= 1'b0;
        end else begin
            reload <= commit && new_ok;
            if (commit && new_ok) begin
                index <= new_idx;
            end
        end
    end

    assign held = (state == HELD);

endmodule
